// File: rtl/apb_timer_pkg.sv
// apb_timer shared definitions.
// Register indices, CTRL bit positions, FSM states.
package apb_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_t;

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_LOAD   = 3'd1;
   localparam logic [2:0] REG_COUNT  = 3'd2;
   localparam logic [2:0] REG_STATUS = 3'd3;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_AR  = 1;
   localparam int CTRL_IRQ = 2;
   localparam int CTRL_PS  = 8;

endpackage

// File: rtl/apb_timer_if.sv
// APB3 bus bundle between the SoC master
// and the timer slave.
interface apb_timer_if;

   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;

   modport master (
      output PSEL, PENABLE, PWRITE,
      output PADDR, PWDATA,
      input  PRDATA, PREADY
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE,
      input  PADDR, PWDATA,
      output PRDATA, PREADY
   );

endinterface

// File: rtl/timer_core.sv
// Prescaler plus down-counter with expiry
// and optional auto-reload.
module timer_core #(
   parameter int CNT_W = 32
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             en,
   input  logic             auto_reload,
   input  logic [7:0]       prescale,
   input  logic             load_we,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             expire_pulse,
   output logic             en_clr
);

   logic [7:0] presc;
   logic       tick;
   logic       zero;

   assign tick = en & (presc == prescale);
   assign zero = (count == '0);

   // a LOAD write swallows a coincident tick
   assign expire_pulse = tick & zero & ~load_we;
   assign en_clr       = expire_pulse & ~auto_reload;

   // prescaler and counter update
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         presc <= '0;
         count <= '0;
      end else if (load_we) begin
         presc <= '0;
         count <= load_val;
      end else if (!en) begin
         presc <= '0;
      end else begin
         presc <= tick ? 8'd0 : presc + 8'd1;
         if (tick) begin
            if (!zero)
               count <= count - CNT_W'(1);
            else if (auto_reload)
               count <= load_val;
         end
      end
   end

endmodule

// File: rtl/apb_timer.sv
// APB3 timer slave: handshake FSM, register
// file and read mux around timer_core.
module apb_timer
   import apb_timer_pkg::*;
#(
   parameter int WAIT_STATES = 0,
   parameter int CNT_W       = 32
) (
   input  logic      PCLK,
   input  logic      PRESETn,
   apb_timer_if.slave bus,
   output logic      irq
);

   localparam logic [2:0] WS = 3'(WAIT_STATES);

   apb_state_t state, state_nxt;
   logic [2:0] wait_cnt, wait_nxt;

   logic             access;
   logic             wr;
   logic [2:0]       idx;
   logic             wr_ctrl, wr_load, wr_stat;
   logic             ctrl_en, ctrl_ar, ctrl_ie;
   logic [7:0]       ctrl_ps;
   logic [CNT_W-1:0] load_q;
   logic [CNT_W-1:0] load_val;
   logic [CNT_W-1:0] count;
   logic             expired;
   logic             expire_pulse;
   logic             en_clr;
   logic             unused_bits;

   assign unused_bits = ^{bus.PADDR[31:5],
                          bus.PADDR[1:0],
                          bus.PWDATA};

   assign idx    = bus.PADDR[4:2];
   assign access = bus.PSEL & bus.PENABLE;

   // gating on state makes PREADY fall with reset
   assign bus.PREADY = access
                     & (state != ST_IDLE)
                     & (wait_cnt == WS);

   assign wr      = bus.PREADY & bus.PWRITE;
   assign wr_ctrl = wr & (idx == REG_CTRL);
   assign wr_load = wr & (idx == REG_LOAD);
   assign wr_stat = wr & (idx == REG_STATUS);

   // handshake state register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // handshake next state and wait counting
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      unique case (state)
         ST_IDLE: begin
            if (bus.PSEL & ~bus.PENABLE)
               state_nxt = ST_SETUP;
         end
         ST_SETUP, ST_ACCESS: begin
            if (!bus.PSEL || bus.PREADY) begin
               state_nxt = ST_IDLE;
               wait_nxt  = '0;
            end else if (bus.PENABLE) begin
               state_nxt = ST_ACCESS;
               wait_nxt  = wait_cnt + 3'd1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            wait_nxt  = '0;
         end
      endcase
   end

   // CTRL: a bus write beats a hardware EN clear
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ctrl_en <= 1'b0;
         ctrl_ar <= 1'b0;
         ctrl_ie <= 1'b0;
         ctrl_ps <= '0;
      end else if (wr_ctrl) begin
         ctrl_en <= bus.PWDATA[CTRL_EN];
         ctrl_ar <= bus.PWDATA[CTRL_AR];
         ctrl_ie <= bus.PWDATA[CTRL_IRQ];
         ctrl_ps <= bus.PWDATA[CTRL_PS +: 8];
      end else if (en_clr) begin
         ctrl_en <= 1'b0;
      end
   end

   // LOAD holding register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         load_q <= '0;
      else if (wr_load)
         load_q <= bus.PWDATA[CNT_W-1:0];
   end

   // STATUS: expiry set beats W1C
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         expired <= 1'b0;
      else if (expire_pulse)
         expired <= 1'b1;
      else if (wr_stat & bus.PWDATA[0])
         expired <= 1'b0;
   end

   assign load_val = wr_load ? bus.PWDATA[CNT_W-1:0]
                             : load_q;

   timer_core #(.CNT_W(CNT_W)) u_core (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .en           (ctrl_en),
      .auto_reload  (ctrl_ar),
      .prescale     (ctrl_ps),
      .load_we      (wr_load),
      .load_val     (load_val),
      .count        (count),
      .expire_pulse (expire_pulse),
      .en_clr       (en_clr)
   );

   assign irq = expired & ctrl_ie;

   // read mux, zero outside read access
   always_comb begin
      bus.PRDATA = '0;
      if (access & ~bus.PWRITE) begin
         case (idx)
            REG_CTRL:   bus.PRDATA = {16'd0, ctrl_ps, 5'd0,
                                      ctrl_ie, ctrl_ar,
                                      ctrl_en};
            REG_LOAD:   bus.PRDATA = 32'(load_q);
            REG_COUNT:  bus.PRDATA = 32'(count);
            REG_STATUS: bus.PRDATA = {31'd0, expired};
            default:    bus.PRDATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer with
// two wait states and a tick-count model.
module tb_apb_timer;

   localparam logic [31:0] A_CTRL = 32'h00;
   localparam logic [31:0] A_LOAD = 32'h04;
   localparam logic [31:0] A_CNT  = 32'h08;
   localparam logic [31:0] A_STAT = 32'h0C;

   logic PCLK = 1'b0;
   logic PRESETn = 1'b0;
   logic irq;

   apb_timer_if bus ();

   apb_timer #(
      .WAIT_STATES (2),
      .CNT_W       (32)
   ) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus),
      .irq     (irq)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int last_acc, last_cyc, commit_cyc;
   logic last_irq;
   logic [31:0] rd, dummy;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   // starts at posedge+1; leaves at posedge+1
   task automatic xfer(input bit w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       output logic [31:0] r);
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = w;
      bus.PADDR   = a;
      bus.PWDATA  = d;
      r = '0;
      last_acc = 0;
      @(posedge PCLK);
      #1;
      bus.PENABLE = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge PCLK);
         if (bus.PREADY === 1'b1) begin
            last_acc = i;
            r        = bus.PRDATA;
            last_irq = irq;
            last_cyc = cyc;
            break;
         end
         @(posedge PCLK);
         #1;
      end
      if (last_acc == 0) begin
         tests++;
         fails++;
         $error("FAIL timeout addr=%h no PREADY", a);
      end
      @(posedge PCLK);
      #1;
      commit_cyc  = cyc;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a,
                     input logic [31:0] d);
      xfer(1'b1, a, d, dummy);
   endtask

   task automatic rdr(input logic [31:0] a);
      xfer(1'b0, a, 32'h0, rd);
   endtask

   // k enabled edges after start -> expected state
   function automatic void model(
      input int L, input int P, input bit ar,
      input int k,
      output int cnt, output bit ex, output bit en);
      int ticks;
      ticks = k / (P + 1);
      en = 1'b1;
      if (ar) begin
         cnt = L - (ticks % (L + 1));
         ex  = (ticks >= L + 1);
      end else if (ticks <= L) begin
         cnt = L - ticks;
         ex  = 1'b0;
      end else begin
         cnt = 0;
         ex  = 1'b1;
         en  = 1'b0;
      end
   endfunction

   task automatic run(input int L, input int P,
                      input bit ar, input bit ie,
                      input int nreads);
      logic [31:0] ctrl;
      int start, cnt;
      bit ex, en;
      ctrl = (32'(P) << 8) | (32'(ie) << 2)
           | (32'(ar) << 1) | 32'h1;
      wr(A_CTRL, 32'h0);
      wr(A_STAT, 32'h1);
      wr(A_LOAD, 32'(L));
      wr(A_CTRL, ctrl);
      start = commit_cyc;
      for (int i = 0; i < nreads; i++) begin
         idle($urandom_range(0, 5));
         rdr(A_CNT);
         model(L, P, ar, last_cyc - start, cnt, ex, en);
         chk("count", rd, 32'(cnt));
         rdr(A_STAT);
         model(L, P, ar, last_cyc - start, cnt, ex, en);
         chk("status", rd, {31'd0, ex});
         chk("irq", {31'd0, last_irq}, {31'd0, ex & ie});
         rdr(A_CTRL);
         model(L, P, ar, last_cyc - start, cnt, ex, en);
         chk("ctrl_en", rd, (ctrl & 32'hFFFF_FFFE) | 32'(en));
      end
   endtask

   int start_w;
   logic [31:0] d, c;

   initial begin
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b0;
      bus.PADDR   = '0;
      bus.PWDATA  = '0;

      // reset
      repeat (3) @(posedge PCLK);
      #1;
      chk("rst_pready", {31'd0, bus.PREADY}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      PRESETn = 1'b1;
      idle(1);
      for (int i = 0; i < 8; i++) begin
         rdr(32'(i * 4));
         chk("rst_reg", rd, 32'd0);
         chk("rd_latency", 32'(last_acc), 32'd3);
      end

      // unmapped and read-only writes ignored
      wr(32'h14, 32'hFFFF_FFFF);
      chk("wr_latency", 32'(last_acc), 32'd3);
      rdr(32'h14);
      chk("unmapped", rd, 32'd0);
      wr(A_CNT, 32'h1234);
      rdr(A_CNT);
      chk("count_ro", rd, 32'd0);

      // random register readback with EN off
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         wr(A_LOAD, d);
         rdr(A_LOAD);
         chk("load_rb", rd, d);
         rdr(A_CNT);
         chk("load_cnt", rd, d);
         c = $urandom & 32'hFFFF_FFFE;
         wr(A_CTRL, c);
         rdr(A_CTRL);
         chk("ctrl_rb", rd, c & 32'h0000_FF06);
      end
      wr(A_CTRL, 32'h0);

      // directed one-shot and auto-reload
      run(5, 0, 1'b0, 1'b1, 6);
      run(2, 3, 1'b1, 1'b0, 8);

      // random counter configurations
      for (int i = 0; i < 3; i++)
         run($urandom_range(1, 9), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'b1, 5);

      // W1C landing on the expiry edge
      wr(A_CTRL, 32'h0);
      wr(A_STAT, 32'h1);
      wr(A_LOAD, 32'h1);
      wr(A_CTRL, 32'h0105);
      start_w = commit_cyc;
      wr(A_STAT, 32'h1);
      chk("w1c_align", 32'(commit_cyc - start_w), 32'd4);
      rdr(A_STAT);
      chk("w1c_set_wins", rd, 32'd1);
      chk("w1c_irq_hi", {31'd0, last_irq}, 32'd1);
      wr(A_STAT, 32'h1);
      rdr(A_STAT);
      chk("w1c_clear", rd, 32'd0);
      chk("w1c_irq_lo", {31'd0, irq}, 32'd0);

      // reset during the ready cycle of a LOAD write
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b1;
      bus.PADDR   = A_LOAD;
      bus.PWDATA  = 32'h0000_ABCD;
      idle(1);
      bus.PENABLE = 1'b1;
      idle(2);
      chk("arst_ready_pre", {31'd0, bus.PREADY}, 32'd1);
      PRESETn = 1'b0;
      #1;
      chk("arst_ready_drop", {31'd0, bus.PREADY}, 32'd0);
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      idle(2);
      PRESETn = 1'b1;
      idle(1);
      rdr(A_LOAD);
      chk("arst_load", rd, 32'd0);
      rdr(A_CTRL);
      chk("arst_ctrl", rd, 32'd0);
      wr(A_LOAD, 32'd7);
      chk("arst_next_lat", 32'(last_acc), 32'd3);
      rdr(A_LOAD);
      chk("arst_next_load", rd, 32'd7);

      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "watchdog");
   end

endmodule
